// File: rtl/nec_frame_decoder.sv
// NEC IR frame decoder: synchronizes the raw receiver line, measures pulse widths in
// microseconds and validates leader, data bits, stop pulse and the inverse bytes.
module nec_frame_decoder #(
   parameter int CLK_HZ = 50_000_000,
   parameter int TOL_US = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ir_signal,
   output logic [31:0] word,
   output logic [7:0]  addr,
   output logic [7:0]  cmd,
   output logic        frame_valid,
   output logic        repeat_code,
   output logic        frame_err,
   output logic        busy
);

   // state    | meaning
   // IDLE     | line idle, waiting for a leader fall
   // LEAD_LO  | timing the 9 ms leader low
   // LEAD_HI  | timing the leader high (4.5 ms frame, 2.25 ms repeat)
   // BIT_LO   | timing the low mark of a data bit
   // BIT_HI   | timing the high space that encodes the data bit
   // STOP     | all 32 bits in, timing the stop mark
   // RPT_STOP | timing the stop mark of a repeat frame
   typedef enum logic [2:0] {IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP, RPT_STOP} state_t;

   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [15:0] LEAD_LO_MIN = 16'(9000 - TOL_US);
   localparam logic [15:0] LEAD_LO_MAX = 16'(9000 + TOL_US);
   localparam logic [15:0] LEAD_HI_MIN = 16'(4500 - TOL_US);
   localparam logic [15:0] LEAD_HI_MAX = 16'(4500 + TOL_US);
   localparam logic [15:0] RPT_HI_MIN  = 16'(2250 - TOL_US);
   localparam logic [15:0] RPT_HI_MAX  = 16'(2250 + TOL_US);
   localparam logic [15:0] SHORT_MIN   = 16'd400;
   localparam logic [15:0] SHORT_MAX   = 16'd750;
   localparam logic [15:0] LONG_MIN    = 16'd1400;
   localparam logic [15:0] LONG_MAX    = 16'd2000;
   localparam logic [15:0] TIMEOUT_US  = 16'd11000;

   state_t        state, state_nxt;
   logic          sync1, sync2, sync3;
   logic          rise, fall, edge_any;
   logic [TW-1:0] tick_cnt;
   logic          us_tick;
   logic [15:0]   dur;
   logic [4:0]    bit_cnt;
   logic [31:0]   sh;
   logic          clr_cnt, shift_en, bit_val, load_word;
   logic          valid_nxt, rpt_nxt, err_nxt;
   logic          timeout, inv_ok;

   function automatic logic in_rng(input logic [15:0] d, input logic [15:0] lo,
                                   input logic [15:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

   assign fall     = sync3 & ~sync2;
   assign rise     = ~sync3 & sync2;
   assign edge_any = fall | rise;
   assign us_tick  = (tick_cnt == '0);
   assign timeout  = (state != IDLE) && (dur > TIMEOUT_US);
   assign inv_ok   = (sh[15:8] == ~sh[7:0]) && (sh[31:24] == ~sh[23:16]);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1       <= 1'b1;
         sync2       <= 1'b1;
         sync3       <= 1'b1;
         tick_cnt    <= '0;
         dur         <= '0;
         state       <= IDLE;
         bit_cnt     <= '0;
         sh          <= '0;
         word        <= '0;
         frame_valid <= 1'b0;
         repeat_code <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         sync1 <= ir_signal;
         sync2 <= sync1;
         sync3 <= sync2;
         tick_cnt <= us_tick ? TW'(DIV - 1) : tick_cnt - 1'b1;
         if (edge_any)
            dur <= '0;
         else if (us_tick && dur != 16'hFFFF)
            dur <= dur + 16'd1;
         state <= state_nxt;
         if (clr_cnt)
            bit_cnt <= '0;
         else if (shift_en) begin
            sh[bit_cnt] <= bit_val;
            bit_cnt     <= bit_cnt + 5'd1;
         end
         if (load_word)
            word <= sh;
         frame_valid <= valid_nxt;
         repeat_code <= rpt_nxt;
         frame_err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clr_cnt   = 1'b0;
      shift_en  = 1'b0;
      bit_val   = 1'b0;
      load_word = 1'b0;
      valid_nxt = 1'b0;
      rpt_nxt   = 1'b0;
      err_nxt   = 1'b0;
      // A timeout wins over an edge in the same cycle; that edge is simply dropped.
      if (timeout) begin
         state_nxt = IDLE;
         err_nxt   = 1'b1;
      end else if (edge_any) begin
         state_nxt = IDLE;
         unique case (state)
            IDLE: if (fall) state_nxt = LEAD_LO;
            LEAD_LO:
               if (rise && in_rng(dur, LEAD_LO_MIN, LEAD_LO_MAX)) state_nxt = LEAD_HI;
               else err_nxt = 1'b1;
            LEAD_HI:
               if (fall && in_rng(dur, LEAD_HI_MIN, LEAD_HI_MAX)) begin
                  state_nxt = BIT_LO;
                  clr_cnt   = 1'b1;
               end else if (fall && in_rng(dur, RPT_HI_MIN, RPT_HI_MAX))
                  state_nxt = RPT_STOP;
               else err_nxt = 1'b1;
            BIT_LO:
               if (rise && in_rng(dur, SHORT_MIN, SHORT_MAX)) state_nxt = BIT_HI;
               else err_nxt = 1'b1;
            BIT_HI:
               if (fall && (in_rng(dur, SHORT_MIN, SHORT_MAX) ||
                            in_rng(dur, LONG_MIN, LONG_MAX))) begin
                  shift_en  = 1'b1;
                  bit_val   = in_rng(dur, LONG_MIN, LONG_MAX);
                  state_nxt = (bit_cnt == 5'd31) ? STOP : BIT_LO;
               end else err_nxt = 1'b1;
            STOP:
               if (rise && in_rng(dur, SHORT_MIN, SHORT_MAX) && inv_ok) begin
                  load_word = 1'b1;
                  valid_nxt = 1'b1;
               end else err_nxt = 1'b1;
            RPT_STOP:
               if (rise && in_rng(dur, SHORT_MIN, SHORT_MAX)) rpt_nxt = 1'b1;
               else err_nxt = 1'b1;
            default: err_nxt = 1'b1;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign addr = word[7:0];
   assign cmd  = word[23:16];

endmodule

// File: tb/tb_nec_frame_decoder.sv
// Scoreboard bench for nec_frame_decoder: frames are described as timed line segments,
// the expected event per frame is derived from the NEC byte rules and queued for a monitor.
module tb_nec_frame_decoder;

   localparam int K_VALID  = 0;
   localparam int K_REPEAT = 1;
   localparam int K_ERR    = 2;

   typedef struct {
      int          kind;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ir_signal = 1'b1;
   logic [31:0] word;
   logic [7:0]  addr, cmd;
   logic        frame_valid, repeat_code, frame_err, busy;

   exp_t        sb[$];
   exp_t        mon_e;
   int          got_kind;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_word = '0;

   nec_frame_decoder #(.CLK_HZ(1_000_000), .TOL_US(500)) dut (
      .clk(clk), .reset(reset), .ir_signal(ir_signal), .word(word), .addr(addr), .cmd(cmd),
      .frame_valid(frame_valid), .repeat_code(repeat_code), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (frame_valid || repeat_code || frame_err) begin
         check("pulse_exclusive", 32'(int'(frame_valid) + int'(repeat_code) + int'(frame_err)), 32'd1);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: fv=%0b rc=%0b fe=%0b, none expected",
                     frame_valid, repeat_code, frame_err);
         end else begin
            mon_e    = sb.pop_front();
            got_kind = frame_valid ? K_VALID : (repeat_code ? K_REPEAT : K_ERR);
            check("pulse_kind", 32'(got_kind), 32'(mon_e.kind));
            check("word", word, mon_e.word);
            if (frame_valid) begin
               check("addr", 32'(addr), 32'(mon_e.word[7:0]));
               check("cmd", 32'(cmd), 32'(mon_e.word[23:16]));
            end
         end
      end
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int rnd(input int lo, input int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction

   task automatic seg(input logic lvl, input int us);
      ir_signal = lvl;
      repeat (us) @(negedge clk);
   endtask

   task automatic push(input int kind, input logic [31:0] w);
      exp_t e;
      e.kind = kind;
      e.word = w;
      sb.push_back(e);
   endtask

   task automatic send_bits(input logic [31:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         seg(1'b0, rnd(450, 700));
         seg(1'b1, w[i] ? rnd(1450, 1950) : rnd(450, 700));
      end
   endtask

   task automatic send_frame(input logic [31:0] w);
      if (w[15:8] == ~w[7:0] && w[31:24] == ~w[23:16]) begin
         model_word = w;
         push(K_VALID, w);
      end else
         push(K_ERR, model_word);
      seg(1'b0, rnd(8700, 9300));
      seg(1'b1, rnd(4200, 4800));
      send_bits(w, 32);
      seg(1'b0, rnd(450, 700));
      seg(1'b1, 3000);
   endtask

   task automatic send_repeat();
      push(K_REPEAT, model_word);
      seg(1'b0, 9000);
      seg(1'b1, 2250);
      seg(1'b0, 562);
      seg(1'b1, 3000);
   endtask

   task automatic drained(input string name);
      check(name, 32'(sb.size()), 32'd0);
   endtask

   logic [31:0] w;

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_word", word, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_pulses", 32'({frame_valid, repeat_code, frame_err}), 32'd0);
      reset = 1'b0;
      seg(1'b1, 100);

      send_frame(nec_word(8'h00, 8'h18));
      drained("frame_e718ff00");
      check("word_e718ff00", word, 32'hE718_FF00);

      send_repeat();
      drained("repeat");
      check("word_after_repeat", word, 32'hE718_FF00);

      send_frame({8'hE6, 8'h18, 8'hFF, 8'h00});
      drained("bad_inverse");
      check("word_after_bad_inverse", word, 32'hE718_FF00);

      push(K_ERR, model_word);
      seg(1'b0, 5000);
      seg(1'b1, 3000);
      drained("short_leader");
      send_frame(nec_word(8'($urandom), 8'($urandom)));
      drained("frame_after_short_leader");

      push(K_ERR, model_word);
      seg(1'b0, 5000);
      check("busy_while_low", 32'(busy), 32'd1);
      seg(1'b0, 6500);
      check("busy_after_timeout", 32'(busy), 32'd0);
      seg(1'b0, 8500);
      seg(1'b1, 3000);
      drained("stuck_low");
      send_frame(nec_word(8'($urandom), 8'($urandom)));
      drained("frame_after_stuck_low");

      w = nec_word(8'($urandom), 8'($urandom));
      seg(1'b0, 9000);
      seg(1'b1, 4500);
      send_bits(w, 16);
      check("busy_mid_frame", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_word = '0;
      check("busy_after_reset", 32'(busy), 32'd0);
      check("word_after_reset", word, 32'd0);
      seg(1'b1, 3000);
      drained("reset_mid_frame");
      send_frame(nec_word(8'($urandom), 8'($urandom)));
      drained("frame_after_reset");

      w = nec_word(8'($urandom), 8'($urandom));
      if ($urandom_range(1, 0) == 1) w[15:8] = w[15:8] ^ 8'(1 << $urandom_range(7, 0));
      send_frame(w);
      send_repeat();
      drained("random_frame_and_repeat");
      check("word_final", word, model_word);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
